adc_spi_capture: RTL and testbench

Parametrised serial-ADC front end that generates cs/sclk, shifts in one frame per sample period and strips leading zero bits. It optionally converts offset-binary codes to two's complement, optionally block-averages 2^AVG_LOG2 samples, and extends the result to OUT_BITS with a one-cycle valid strobe. It sits between the off-chip ADC pins and the servo control datapath.

---
 rtl/adc_spi_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// Serial-ADC front end: generates cs/sclk, shifts in one frame per sample
// period, drops the leading bits, optionally converts offset-binary to two's
// complement, optionally block-averages, and presents a widened sample with
// a one-cycle valid strobe.
module adc_spi_capture #(
    parameter int unsigned ADC_BITS      = 12,
    parameter int unsigned LEAD_ZEROS    = 4,
    parameter int unsigned OUT_BITS      = 16,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 200,
    parameter int unsigned SIGNED_MODE   = 1,
    parameter int unsigned AVG_LOG2      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sdata,
    output logic                       cs,
    output logic                       sclk,
    output logic                       busy,
    output logic [ADC_BITS-1:0]        dato_raw,
    output logic signed [OUT_BITS-1:0] dato_final,
    output logic                       dato_valid
);

    localparam int unsigned FRAME_BITS = LEAD_ZEROS + ADC_BITS;
    localparam int unsigned PER_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int unsigned ACC_W      = ADC_BITS + AVG_LOG2;
    localparam int unsigned CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PER_W-1:0]    per_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ADC_BITS-1:0] shreg;
    logic                done_q;
    logic [ADC_BITS-1:0] conv_q;
    logic                conv_v;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    avg_cnt;

    logic                cs_d;
    logic                sclk_d;
    logic                busy_d;
    logic                start_c;
    logic                sample_c;
    logic                div_end_c;
    logic                last_bit_c;
    logic [ADC_BITS-1:0] conv_c;
    logic [ACC_W-1:0]    conv_ext_c;
    logic [ACC_W-1:0]    acc_sum_c;
    logic [ADC_BITS-1:0] avg_c;
    logic [OUT_BITS-1:0] final_c;
    logic                block_end_c;

    assign div_end_c  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit_c = (bit_cnt == BIT_W'(FRAME_BITS - 1));

    // Sample-period counter; parked at zero while sampling is disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt <= '0;
        end else if (!en) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // FSM state and registered pin outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cs      <= 1'b1;
            sclk    <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cs      <= cs_d;
            sclk    <= sclk_d;
            busy    <= busy_d;
        end
    end

    // Next-state and pin values; LOW with sclk still high is the lead-in half period
    always_comb begin
        state_d  = state_q;
        cs_d     = cs;
        sclk_d   = sclk;
        busy_d   = busy;
        start_c  = 1'b0;
        sample_c = 1'b0;
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if (en && (per_cnt == '0)) begin
                    state_d = LOW;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    start_c = 1'b1;
                end
            end
            LOW: begin
                if (div_end_c) begin
                    if (sclk) begin
                        sclk_d = 1'b0;
                    end else begin
                        sclk_d   = 1'b1;
                        sample_c = 1'b1;
                        state_d  = last_bit_c ? TAIL : HIGH;
                    end
                end
            end
            HIGH: begin
                if (div_end_c) begin
                    sclk_d  = 1'b0;
                    state_d = LOW;
                end
            end
            TAIL: begin
                if (div_end_c) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Half-period timer and frame bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if ((state_q == IDLE) || div_end_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (start_c) begin
                bit_cnt <= '0;
            end else if (sample_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // Shift register; the lead bits fall off the top once the whole frame is in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= sample_c && last_bit_c;
            if (start_c) begin
                shreg <= '0;
            end else if (sample_c) begin
                shreg <= {shreg[ADC_BITS-2:0], sdata};
            end
        end
    end

    assign conv_c = (SIGNED_MODE != 0) ? {~shreg[ADC_BITS-1], shreg[ADC_BITS-2:0]} : shreg;

    // Stage 1: publish raw code and latch the converted value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dato_raw <= '0;
            conv_q   <= '0;
            conv_v   <= 1'b0;
        end else begin
            conv_v <= done_q;
            if (done_q) begin
                dato_raw <= shreg;
                conv_q   <= conv_c;
            end
        end
    end

    assign conv_ext_c  = (SIGNED_MODE != 0) ? ACC_W'($signed(conv_q)) : ACC_W'(conv_q);
    assign acc_sum_c   = acc_q + conv_ext_c;
    assign avg_c       = (SIGNED_MODE != 0) ? ADC_BITS'($signed(acc_sum_c) >>> AVG_LOG2)
                                            : ADC_BITS'(acc_sum_c >> AVG_LOG2);
    assign final_c     = (SIGNED_MODE != 0) ? OUT_BITS'($signed(avg_c)) : OUT_BITS'(avg_c);
    assign block_end_c = (avg_cnt == CNT_W'((1 << AVG_LOG2) - 1));

    // Stage 2: accumulate and emit at block end; with no averaging every sample ends a block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            avg_cnt    <= '0;
            dato_final <= '0;
            dato_valid <= 1'b0;
        end else begin
            dato_valid <= 1'b0;
            if (conv_v) begin
                if (block_end_c) begin
                    acc_q      <= '0;
                    avg_cnt    <= '0;
                    dato_final <= final_c;
                    dato_valid <= 1'b1;
                end else begin
                    acc_q   <= acc_sum_c;
                    avg_cnt <= avg_cnt + CNT_W'(1);
                end
            end else if ((state_q == IDLE) && !en) begin
                acc_q   <= '0;
                avg_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench: three instances (signed default, unipolar, unipolar with
// 4-sample averaging) share clock, reset, enable and the serial data stream.
module tb_adc_spi_capture;

    localparam int CD = 4;
    localparam int FB = 16;

    typedef struct {
        logic [3:0]  lead;
        logic [11:0] code;
        logic [15:0] exp_s;
        logic [15:0] exp_u;
        logic        avg_v;
        logic [15:0] exp_a;
    } vec_t;

    logic clk, rst, en, sdata;
    logic cs_def, sclk_def, busy_def, v_def;
    logic cs_uns, sclk_uns, busy_uns, v_uns;
    logic cs_avg, sclk_avg, busy_avg, v_avg;
    logic [11:0] raw_def, raw_uns, raw_avg;
    logic [15:0] fin_def, fin_uns, fin_avg;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_t0  = 0;
    logic [15:0] tx_q[$];
    vec_t tbl[8];
    vec_t re_tbl[4];
    vec_t v_drop, v_rst;

    adc_spi_capture u_def (
        .clk(clk), .rst(rst), .en(en), .sdata(sdata),
        .cs(cs_def), .sclk(sclk_def), .busy(busy_def),
        .dato_raw(raw_def), .dato_final(fin_def), .dato_valid(v_def)
    );

    adc_spi_capture #(.SIGNED_MODE(0)) u_uns (
        .clk(clk), .rst(rst), .en(en), .sdata(sdata),
        .cs(cs_uns), .sclk(sclk_uns), .busy(busy_uns),
        .dato_raw(raw_uns), .dato_final(fin_uns), .dato_valid(v_uns)
    );

    adc_spi_capture #(.SIGNED_MODE(0), .AVG_LOG2(2)) u_avg (
        .clk(clk), .rst(rst), .en(en), .sdata(sdata),
        .cs(cs_avg), .sclk(sclk_avg), .busy(busy_avg),
        .dato_raw(raw_avg), .dato_final(fin_avg), .dato_valid(v_avg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ADC model: new frame on cs fall, next bit on each sclk fall
    initial begin
        logic [15:0] cur;
        int bidx;
        sdata = 1'b0;
        cur   = '0;
        bidx  = 0;
        forever begin
            @(negedge cs_def or negedge sclk_def);
            if (sclk_def) begin
                cur   = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0000;
                bidx  = 0;
                sdata = 1'b0;
            end else if (bidx < FB) begin
                sdata = cur[15-bidx];
                bidx++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic sclk_model(input int k);
        if (k < CD) return 1'b1;
        if (k >= 2 * CD * FB) return 1'b1;
        return 1'(((k - CD) / CD) % 2);
    endfunction

    function automatic vec_t mk(input logic [3:0] lead, input logic [11:0] code,
                                input logic [15:0] es, input logic [15:0] eu,
                                input logic av, input logic [15:0] ea);
        vec_t v;
        v.lead = lead; v.code = code; v.exp_s = es; v.exp_u = eu; v.avg_v = av; v.exp_a = ea;
        return v;
    endfunction

    // Follow one frame from cs fall through cs rise, checking every cycle
    task automatic run_frame(input vec_t v, input int exp_gap, input int drop_at);
        int w;
        w = 0;
        while (cs_def === 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("frame_start", 32'(cs_def), 32'd0);
        if (exp_gap > 0) chk("frame_gap", 32'(cyc - last_t0), 32'(exp_gap));
        last_t0 = cyc;
        for (int k = 1; k <= 132; k++) begin
            @(negedge clk);
            if (k == drop_at) en = 1'b0;
            chk("cs", 32'(cs_def), 32'(k >= 132));
            chk("busy", 32'(busy_def), 32'(k < 132));
            chk("sclk", 32'(sclk_def), 32'(sclk_model(k)));
            chk("valid_def", 32'(v_def), 32'(k == 130));
            chk("valid_uns", 32'(v_uns), 32'(k == 130));
            chk("valid_avg", 32'(v_avg), 32'((k == 130) && v.avg_v));
            if (k == 129) begin
                chk("raw_def", 32'(raw_def), 32'(v.code));
                chk("raw_uns", 32'(raw_uns), 32'(v.code));
            end
            if (k == 130) begin
                chk("final_def", 32'(fin_def), 32'(v.exp_s));
                chk("final_uns", 32'(fin_uns), 32'(v.exp_u));
                if (v.avg_v) chk("final_avg", 32'(fin_avg), 32'(v.exp_a));
            end
        end
    endtask

    initial begin
        int t;
        int w;
        rst = 1'b1;
        en  = 1'b0;

        tbl[0] = mk(4'h0, 12'h100, 16'hF900, 16'h0100, 1'b0, 16'h0000);
        tbl[1] = mk(4'h0, 12'h200, 16'hFA00, 16'h0200, 1'b0, 16'h0000);
        tbl[2] = mk(4'hF, 12'h300, 16'hFB00, 16'h0300, 1'b0, 16'h0000);
        tbl[3] = mk(4'h0, 12'h400, 16'hFC00, 16'h0400, 1'b1, 16'h0280);
        tbl[4] = mk(4'h0, 12'h800, 16'h0000, 16'h0800, 1'b0, 16'h0000);
        tbl[5] = mk(4'hF, 12'hFFF, 16'h07FF, 16'h0FFF, 1'b0, 16'h0000);
        tbl[6] = mk(4'h0, 12'h000, 16'hF800, 16'h0000, 1'b0, 16'h0000);
        tbl[7] = mk(4'hA, 12'h7FF, 16'hFFFF, 16'h07FF, 1'b1, 16'h07FF);
        v_drop = mk(4'h0, 12'h555, 16'hFD55, 16'h0555, 1'b0, 16'h0000);
        re_tbl[0] = mk(4'h0, 12'h100, 16'hF900, 16'h0100, 1'b0, 16'h0000);
        re_tbl[1] = mk(4'h3, 12'h100, 16'hF900, 16'h0100, 1'b0, 16'h0000);
        re_tbl[2] = mk(4'h0, 12'h100, 16'hF900, 16'h0100, 1'b0, 16'h0000);
        re_tbl[3] = mk(4'h0, 12'h104, 16'hF904, 16'h0104, 1'b1, 16'h0101);
        v_rst = mk(4'h0, 12'h7F0, 16'hFFF0, 16'h07F0, 1'b0, 16'h0000);

        for (int i = 0; i < 8; i++) tx_q.push_back({tbl[i].lead, tbl[i].code});
        tx_q.push_back({v_drop.lead, v_drop.code});
        for (int i = 0; i < 4; i++) tx_q.push_back({re_tbl[i].lead, re_tbl[i].code});
        tx_q.push_back(16'h5ABC);
        tx_q.push_back({v_rst.lead, v_rst.code});

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs_def), 32'd1);
        chk("rst_sclk", 32'(sclk_def), 32'd1);
        chk("rst_busy", 32'(busy_def), 32'd0);
        chk("rst_raw", 32'(raw_def), 32'd0);
        chk("rst_final", 32'(fin_def), 32'd0);
        chk("rst_valid", 32'(v_def), 32'd0);

        rst = 1'b1;
        en  = 1'b1;
        t   = cyc;
        @(negedge clk);
        chk("first_start_edge", 32'(cyc - t), 32'd1);
        for (int i = 0; i < 8; i++) run_frame(tbl[i], (i == 0) ? 0 : 200, -1);

        // enable dropped mid-frame: frame completes, then nothing starts
        run_frame(v_drop, 200, 50);
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            chk("en_off_cs", 32'(cs_def), 32'd1);
            chk("en_off_valid", 32'(v_avg), 32'd0);
        end
        en = 1'b1;
        t  = cyc;
        @(negedge clk);
        chk("restart_cs", 32'(cs_def), 32'd0);
        chk("restart_edge", 32'(cyc - t), 32'd1);
        for (int i = 0; i < 4; i++) run_frame(re_tbl[i], (i == 0) ? 0 : 200, -1);

        // reset pulsed mid-frame
        w = 0;
        while (cs_def === 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("pre_rst_start", 32'(cs_def), 32'd0);
        repeat (60) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(cs_def), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_def), 32'd1);
        chk("mid_rst_busy", 32'(busy_def), 32'd0);
        chk("mid_rst_raw", 32'(raw_def), 32'd0);
        chk("mid_rst_final_def", 32'(fin_def), 32'd0);
        chk("mid_rst_final_avg", 32'(fin_avg), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("in_rst_valid", 32'(v_def | v_uns | v_avg), 32'd0);
            chk("in_rst_cs", 32'(cs_def), 32'd1);
        end
        rst = 1'b1;
        t   = cyc;
        @(negedge clk);
        chk("post_rst_cs", 32'(cs_def), 32'd0);
        chk("post_rst_edge", 32'(cyc - t), 32'd1);
        run_frame(v_rst, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
